// File: rtl/ecp5pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ecp5pll_phase_ctrl
// Purpose : Sequences the ECP5 PLL dynamic phase-shift inputs. It accepts
//           "shift channel X by N steps" commands, produces phasestep or
//           phaseloadreg pulses with fixed setup, width and gap, can wait for
//           lock, and tracks the applied fine-phase offset per channel.
// Revision: 1.0 - initial release
// ============================================================================
module ecp5pll_phase_ctrl #(
  parameter int SETUP        = 2,
  parameter int PULSE        = 4,
  parameter int GAP          = 4,
  parameter int LOCK_WAIT    = 1,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_sel,
  input  logic        cmd_dir,
  input  logic [7:0]  cmd_steps,
  input  logic        locked,
  output logic [1:0]  phasesel,
  output logic        phasedir,
  output logic        phasestep,
  output logic        phaseloadreg,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [39:0] phase_pos
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_SETUP    = 3'd1;
  localparam logic [2:0] c_PULSE    = 3'd2;
  localparam logic [2:0] c_GAP      = 3'd3;
  localparam logic [2:0] c_LOCKWAIT = 3'd4;

  localparam logic [15:0] c_SETUP_LAST = 16'(SETUP - 1);
  localparam logic [15:0] c_PULSE_LAST = 16'(PULSE - 1);
  localparam logic [15:0] c_GAP_LAST   = 16'(GAP - 1);
  localparam logic [15:0] c_TIMEOUT    = 16'(LOCK_TIMEOUT);

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_remaining;
  logic        r_load;
  logic [1:0]  r_phasesel;
  logic        r_phasedir;
  logic        r_phasestep;
  logic        r_phaseloadreg;
  logic        r_done;
  logic        r_timeout_err;
  logic [9:0]  r_pos [4];
  logic        r_lock_meta;
  logic        r_locked_s;
  logic        w_accept;

  // A command is taken only in IDLE and not in the cycle that reports done,
  // so ready reappears the cycle after the done pulse.
  assign cmd_ready    = (r_state == c_IDLE) && !r_done;
  assign w_accept     = cmd_valid && cmd_ready;
  assign busy         = (r_state != c_IDLE);
  assign done         = r_done;
  assign timeout_err  = r_timeout_err;
  assign phasesel     = r_phasesel;
  assign phasedir     = r_phasedir;
  assign phasestep    = r_phasestep;
  assign phaseloadreg = r_phaseloadreg;

  for (genvar g = 0; g < 4; g++) begin : g_pos
    assign phase_pos[10*g +: 10] = r_pos[g];
  end

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_locked_s  <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_locked_s  <= r_lock_meta;
    end
  end

  // Main sequencer: one shared counter times setup, pulse, gap and lock wait.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_state        <= c_IDLE;
      r_cnt          <= '0;
      r_remaining    <= '0;
      r_load         <= 1'b0;
      r_phasesel     <= '0;
      r_phasedir     <= 1'b0;
      r_phasestep    <= 1'b0;
      r_phaseloadreg <= 1'b0;
      r_done         <= 1'b0;
      r_timeout_err  <= 1'b0;
      for (int i = 0; i < 4; i++) r_pos[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_phasesel    <= cmd_sel;
            r_phasedir    <= cmd_dir;
            r_remaining   <= cmd_steps;
            r_load        <= (cmd_steps == 8'd0);
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
            r_state       <= c_SETUP;
          end
        end
        c_SETUP: begin
          if (r_cnt == c_SETUP_LAST) begin
            r_cnt   <= '0;
            r_state <= c_PULSE;
            if (r_load) r_phaseloadreg <= 1'b1;
            else        r_phasestep    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_PULSE: begin
          if (r_cnt == c_PULSE_LAST) begin
            r_cnt          <= '0;
            r_state        <= c_GAP;
            r_phasestep    <= 1'b0;
            r_phaseloadreg <= 1'b0;
            if (r_load) begin
              r_pos[r_phasesel] <= '0;
            end else begin
              // 10-bit arithmetic gives the mod-1024 wrap in both directions
              r_pos[r_phasesel] <= r_phasedir ? r_pos[r_phasesel] - 10'd1
                                              : r_pos[r_phasesel] + 10'd1;
              r_remaining       <= r_remaining - 8'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_cnt <= '0;
            if (r_remaining != 8'd0) begin
              r_state <= c_PULSE;
              if (r_load) r_phaseloadreg <= 1'b1;
              else        r_phasestep    <= 1'b1;
            end else if (LOCK_WAIT != 0) begin
              r_state <= c_LOCKWAIT;
            end else begin
              r_done  <= 1'b1;
              r_state <= c_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_LOCKWAIT: begin
          if (r_locked_s) begin
            r_done  <= 1'b1;
            r_state <= c_IDLE;
          end else if (r_cnt == c_TIMEOUT) begin
            r_timeout_err <= 1'b1;
            r_done        <= 1'b1;
            r_state       <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
